mac_unit: RTL and testbench
===========================

MAC_UNIT -- requirements
Module: mac_unit

Interface
REQ-001 Parameter WIDTH_A, default 5, SHALL set the width of multiplicand A.
REQ-002 Parameter WIDTH_B, default 7, SHALL set the width of multiplier B.
REQ-003 Local width W = WIDTH_A+WIDTH_B SHALL be the width of C and Y.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-006 in_valid  input  1  SHALL qualify A, B, C and acc for one operation per cycle.
REQ-007 A  input  WIDTH_A  SHALL be the unsigned multiplicand.
REQ-008 B  input  WIDTH_B  SHALL be the unsigned multiplier.
REQ-009 C  input  W  SHALL be the unsigned addend.
REQ-010 acc  input  1  SHALL select the current Y as addend instead of C (accumulate mode).
REQ-011 Y  output  W  SHALL be the registered result.
REQ-012 out_valid  output  1  SHALL mark the cycle in which Y holds a new result.
REQ-013 ovf  output  1  SHALL flag a carry out of bit W-1 for the result currently in Y.

Function
REQ-014 The product A*B SHALL be computed unsigned at full width W (it never overflows W).
REQ-015 The addend SHALL be Y when acc=1, else C.
REQ-016 When in_valid=1, the next Y SHALL be (A*B + addend) mod 2^W, and the next ovf SHALL be bit W of the (W+1)-bit sum.
REQ-017 Latency SHALL be exactly one cycle: out_valid=1 in the cycle after in_valid=1, else 0.
REQ-018 When in_valid=0, Y and ovf SHALL hold their values.
REQ-019 Back-to-back in_valid SHALL be accepted every cycle with no stall; in accumulate mode, each operation SHALL use the Y produced by the previous accepted operation.
REQ-020 Wrap-around SHALL be modular with no saturation; ovf SHALL be set only for the operation that carried, and cleared by the next accepted non-carrying operation.
REQ-021 Inputs with in_valid=0 SHALL have no effect, including acc.

Reset
REQ-022 While rst=1 at a clock edge, Y SHALL be 0, ovf SHALL be 0, and out_valid SHALL be 0, regardless of in_valid.
REQ-023 An operation presented in the same cycle as rst=1 SHALL be discarded.
REQ-024 After reset, the first accumulate operation SHALL use addend 0.

Structure
REQ-025 A shared package mac_pkg SHALL hold the default width constants (5, 7) and the derived width function W.
REQ-026 The block SHALL be a single module; the multiply-add datapath MAY be a combinational sub-module mac_datapath (product plus addend mux plus adder with carry out).

Verification
REQ-027 A=13, B=23, C=1012, acc=0, in_valid pulse -> next cycle Y=1311, ovf=0, out_valid=1.
REQ-028 A=15, B=21, C=598, acc=0 -> Y=913, ovf=0.
REQ-029 A=31, B=127, C=4095 -> Y=3936, ovf=1; then A=0, B=0, C=5 -> Y=5, ovf=0.
REQ-030 Reset, then acc=1 with A=2, B=3 for three consecutive cycles -> Y=6, 12, 18; out_valid=1 on each cycle.
REQ-031 in_valid=0 with changing A, B, C -> Y holds and out_valid=0.
REQ-032 rst=1 asserted mid-stream with in_valid=1 -> next cycle Y=0, ovf=0, out_valid=0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared width constants for the multiply-accumulate unit.
// The result width is the sum of the operand widths, so the product never exceeds it.
package mac_pkg;

  localparam int WIDTH_A_DEF = 5;
  localparam int WIDTH_B_DEF = 7;

  function automatic int mac_width(input int width_a, input int width_b);
    return width_a + width_b;
  endfunction

endpackage

// File: rtl/mac_datapath.sv
// Combinational multiply-add: full-width unsigned product, addend select, and the
// adder with its carry out of the top result bit.
module mac_datapath
  import mac_pkg::*;
#(
  parameter int WIDTH_A = WIDTH_A_DEF,
  parameter int WIDTH_B = WIDTH_B_DEF,
  parameter int W       = mac_width(WIDTH_A, WIDTH_B)
) (
  input  logic [WIDTH_A-1:0] a,
  input  logic [WIDTH_B-1:0] b,
  input  logic [W-1:0]       c,
  input  logic [W-1:0]       y,
  input  logic               acc,
  output logic [W-1:0]       sum,
  output logic               carry
);

  logic [W-1:0] product;
  logic [W-1:0] addend;
  logic [W:0]   sum_full;

  // Operands are widened before multiplying so the product is evaluated at W bits.
  assign product  = W'(a) * W'(b);
  assign addend   = acc ? y : c;
  assign sum_full = {1'b0, product} + {1'b0, addend};
  assign sum      = sum_full[W-1:0];
  assign carry    = sum_full[W];

endmodule

// File: rtl/mac_unit.sv
// Single-cycle-latency unsigned multiply-accumulate with registered result and carry flag.
// Accumulate mode feeds the current Y back as the addend.
module mac_unit
  import mac_pkg::*;
#(
  parameter int WIDTH_A = WIDTH_A_DEF,
  parameter int WIDTH_B = WIDTH_B_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic [WIDTH_A-1:0]                    A,
  input  logic [WIDTH_B-1:0]                    B,
  input  logic [mac_width(WIDTH_A, WIDTH_B)-1:0] C,
  input  logic                                  acc,
  output logic [mac_width(WIDTH_A, WIDTH_B)-1:0] Y,
  output logic                                  out_valid,
  output logic                                  ovf
);

  localparam int W = mac_width(WIDTH_A, WIDTH_B);

  logic [W-1:0] sum;
  logic         carry;

  mac_datapath #(
    .WIDTH_A (WIDTH_A),
    .WIDTH_B (WIDTH_B),
    .W       (W)
  ) u_datapath (
    .a     (A),
    .b     (B),
    .c     (C),
    .y     (Y),
    .acc   (acc),
    .sum   (sum),
    .carry (carry)
  );

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      Y         <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Y   <= sum;
        ovf <= carry;
      end
    end
  end

endmodule

// File: tb/tb_mac_unit.sv
// Self-checking bench for mac_unit: directed vector table followed by randomized
// traffic compared against an arithmetic reference model.
module tb_mac_unit;

  localparam int WA = 5;
  localparam int WB = 7;
  localparam int W  = 12;
  localparam int MODULUS = 1 << W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [WA-1:0] A;
  logic [WB-1:0] B;
  logic [W-1:0]  C;
  logic          acc;
  logic [W-1:0]  Y;
  logic          out_valid;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_unit #(.WIDTH_A(WA), .WIDTH_B(WB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .C         (C),
    .acc       (acc),
    .Y         (Y),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  typedef struct packed {
    logic          rst;
    logic          iv;
    logic          acc;
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic [W-1:0]  c;
    logic [W-1:0]  ey;
    logic          eovf;
    logic          eov;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl [NVEC];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic ac,
                       input int a, input int b, input int c);
    rst      = r;
    in_valid = iv;
    acc      = ac;
    A        = WA'(a);
    B        = WB'(b);
    C        = W'(c);
  endtask

  // One clock edge, then sample a little after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic iv, input logic ac,
                              input int a, input int b, input int c,
                              input int ey, input logic eovf, input logic eov);
    vec_t v;
    v.rst  = r;    v.iv  = iv;  v.acc = ac;
    v.a    = WA'(a); v.b = WB'(b); v.c = W'(c);
    v.ey   = W'(ey); v.eovf = eovf; v.eov = eov;
    return v;
  endfunction

  // Reference model state: results are plain integer arithmetic modulo 2^W.
  int  m_y;
  bit  m_ovf;
  bit  m_ov;

  initial begin
    //               rst iv acc  a    b    c      Y    ovf ov
    tbl[0]  = mk(1, 1, 0, 13,  23, 1012,    0, 0, 0);  // op during reset discarded
    tbl[1]  = mk(0, 1, 0, 13,  23, 1012, 1311, 0, 1);
    tbl[2]  = mk(0, 1, 0, 15,  21,  598,  913, 0, 1);
    tbl[3]  = mk(0, 1, 0, 31, 127, 4095, 3936, 1, 1);
    tbl[4]  = mk(0, 1, 0,  0,   0,    5,    5, 0, 1);
    tbl[5]  = mk(0, 0, 0,  7,   9,  100,    5, 0, 0);
    tbl[6]  = mk(0, 0, 1,  3,   3,  200,    5, 0, 0);  // acc ignored when idle
    tbl[7]  = mk(1, 0, 0,  0,   0,    0,    0, 0, 0);
    tbl[8]  = mk(0, 1, 1,  2,   3,  999,    6, 0, 1);
    tbl[9]  = mk(0, 1, 1,  2,   3,  999,   12, 0, 1);
    tbl[10] = mk(0, 1, 1,  2,   3,  999,   18, 0, 1);
    tbl[11] = mk(0, 1, 1, 31, 127, 4095, 3955, 0, 1);
    tbl[12] = mk(0, 1, 1, 31, 127,    0, 3796, 1, 1);
    tbl[13] = mk(0, 0, 0,  1,   1,    1, 3796, 1, 0);  // ovf held while idle
    tbl[14] = mk(0, 1, 0,  0,   0,    0,    0, 0, 1);
    tbl[15] = mk(0, 1, 0, 31, 127, 1000,  841, 1, 1);
    tbl[16] = mk(1, 1, 1, 31, 127, 4095,    0, 0, 0);  // reset mid-stream
    tbl[17] = mk(0, 1, 1,  1,   1,  777,    1, 0, 1);  // first acc after reset adds 0

    drive(1, 0, 0, 0, 0, 0);
    step();
    check("reset_y", int'(Y), 0);
    check("reset_ovf", int'(ovf), 0);
    check("reset_out_valid", int'(out_valid), 0);

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].acc, int'(tbl[i].a), int'(tbl[i].b), int'(tbl[i].c));
      step();
      check($sformatf("vec%0d_y", i), int'(Y), int'(tbl[i].ey));
      check($sformatf("vec%0d_ovf", i), int'(ovf), int'(tbl[i].eovf));
      check($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(tbl[i].eov));
    end

    // Hand-written sequence: accumulate interleaved with idle cycles keeps chaining.
    drive(1, 0, 0, 0, 0, 0);
    step();
    drive(0, 1, 1, 10, 100, 0);   step();  check("seq_acc1", int'(Y), 1000);
    drive(0, 0, 1, 31, 127, 0);   step();  check("seq_idle", int'(Y), 1000);
    drive(0, 1, 1, 10, 100, 0);   step();  check("seq_acc2", int'(Y), 2000);
    drive(0, 1, 1, 20, 110, 0);   step();  check("seq_acc3_y", int'(Y), 4200 - MODULUS);
    check("seq_acc3_ovf", int'(ovf), 1);
    drive(0, 1, 1, 0, 0, 0);      step();  check("seq_acc4_ovf", int'(ovf), 0);
    check("seq_acc4_y", int'(Y), 104);

    // Randomized traffic against the reference model.
    drive(1, 0, 0, 0, 0, 0);
    step();
    m_y = 0; m_ovf = 0; m_ov = 0;
    for (int n = 0; n < 400; n++) begin
      logic r, iv, ac;
      int a, b, c, s;
      r  = ($urandom_range(0, 31) == 0);
      iv = ($urandom_range(0, 3) != 0);
      ac = $urandom_range(0, 1);
      a  = $urandom_range(0, (1 << WA) - 1);
      b  = $urandom_range(0, (1 << WB) - 1);
      c  = $urandom_range(0, MODULUS - 1);
      drive(r, iv, ac, a, b, c);
      if (r) begin
        m_y = 0; m_ovf = 0; m_ov = 0;
      end else begin
        m_ov = iv;
        if (iv) begin
          s     = a * b + (ac ? m_y : c);
          m_y   = s % MODULUS;
          m_ovf = (s >= MODULUS);
        end
      end
      step();
      check($sformatf("rand%0d_y", n), int'(Y), m_y);
      check($sformatf("rand%0d_ovf", n), int'(ovf), int'(m_ovf));
      check($sformatf("rand%0d_out_valid", n), int'(out_valid), int'(m_ov));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
